// File: rtl/lsu_axi_master_pkg.sv
// Shared types and constants for the load/store unit and its AXI master port.
package lsu_axi_master_pkg;

  typedef struct packed {
    logic       store;
    logic       is_unsigned;
    logic [1:0] size;
  } lsu_op_t;

  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t S_IDLE    = 3'd0;
  localparam lsu_state_t S_RD_ADDR = 3'd1;
  localparam lsu_state_t S_RD_DATA = 3'd2;
  localparam lsu_state_t S_WR_REQ  = 3'd3;
  localparam lsu_state_t S_WR_RESP = 3'd4;
  localparam lsu_state_t S_DONE    = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Debug view: FSM state, write-channel progress and the id of the last response.
  typedef struct packed {
    lsu_state_t state;
    logic       aw_done;
    logic       w_done;
    logic       last_id;
  } lsu_dbg_t;

endpackage

// File: rtl/lsu_axi_master_align.sv
// Byte-lane steering for a 64-bit bus: store replication/strobes, load extract/extend,
// and misalignment detection.
module lsu_align
  import lsu_axi_master_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [2:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] wdata_rep,
  output logic [7:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  base_strb;

  always_comb begin
    shifted    = 32'(rdata >> {addr_lo, 3'b000});
    wdata_rep  = {2{wdata}};
    base_strb  = 8'h0F;
    load_data  = shifted;
    misaligned = 1'b0;
    case (op.size)
      LSU_B: begin
        wdata_rep = {8{wdata[7:0]}};
        base_strb = 8'h01;
        load_data = op.is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      LSU_H: begin
        wdata_rep  = {4{wdata[15:0]}};
        base_strb  = 8'h03;
        load_data  = op.is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      LSU_W: misaligned = (addr_lo[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    wstrb = base_strb << addr_lo;
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store unit driving a dedicated AXI4 master (single-beat bursts).
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valids come
// only from registered state, never from ready, and payload is held while valid && !ready.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter logic AXI_ID     = 1'b1,
  parameter int   DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  resp_misaligned,
  output logic                  busy,
  output lsu_dbg_t              dbg,
  output logic                  axi_awid,
  output logic [31:0]           axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [63:0]           axi_wdata,
  output logic [7:0]            axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  axi_bid,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic                  axi_arid,
  output logic [31:0]           axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic                  axi_rid,
  input  logic [63:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  lsu_state_t            state;
  lsu_op_t               op_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_done, w_done, last_id;

  lsu_op_t     req_op_s, op_sel;
  logic [2:0]  addr_sel;
  logic [31:0] load_data;
  logic        misaligned, aw_hs, w_hs;

  assign req_op_s = lsu_op_t'(req_op);
  // In IDLE the aligner judges the incoming request; afterwards it steers the held one.
  assign op_sel   = (state == S_IDLE) ? req_op_s : op_q;
  assign addr_sel = (state == S_IDLE) ? req_addr[2:0] : addr_q[2:0];

  lsu_align u_align (
    .op         (op_sel),
    .addr_lo    (addr_sel),
    .wdata      (wdata_q),
    .rdata      (axi_rdata),
    .wdata_rep  (axi_wdata),
    .wstrb      (axi_wstrb),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      op_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      last_id         <= 1'b0;
      resp_data       <= '0;
      resp_err        <= 1'b0;
      resp_misaligned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q            <= req_op_s;
          addr_q          <= req_addr;
          wdata_q         <= req_wdata;
          aw_done         <= 1'b0;
          w_done          <= 1'b0;
          resp_data       <= '0;
          resp_err        <= 1'b0;
          resp_misaligned <= misaligned;
          if (misaligned)          state <= S_DONE;
          else if (req_op_s.store) state <= S_WR_REQ;
          else                     state <= S_RD_ADDR;
        end
        S_RD_ADDR: if (axi_arready) state <= S_RD_DATA;
        S_RD_DATA: if (axi_rvalid && axi_rlast) begin
          last_id   <= axi_rid;
          resp_err  <= (axi_rresp != AXI_RESP_OKAY);
          resp_data <= (axi_rresp != AXI_RESP_OKAY) ? '0 : DATA_WIDTH'(load_data);
          state     <= S_DONE;
        end
        S_WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= S_WR_RESP;
        end
        S_WR_RESP: if (axi_bvalid) begin
          last_id  <= axi_bid;
          resp_err <= (axi_bresp != AXI_RESP_OKAY);
          state    <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE) && !rst;
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign dbg        = '{state: state, aw_done: aw_done, w_done: w_done, last_id: last_id};

  assign axi_arid    = AXI_ID;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = {1'b0, op_q.size};
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arvalid = (state == S_RD_ADDR);
  assign axi_rready  = (state == S_RD_DATA);

  assign axi_awid    = AXI_ID;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = {1'b0, op_q.size};
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awvalid = (state == S_WR_REQ) && !aw_done;
  assign axi_wvalid  = (state == S_WR_REQ) && !w_done;
  assign axi_wlast   = 1'b1;
  assign axi_bready  = (state == S_WR_RESP);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: loads, stores, misalignment, bus errors, async reset.
module tb_lsu_axi_master;
  import lsu_axi_master_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_misaligned, busy;
  logic [31:0] resp_data;
  lsu_dbg_t    dbg;
  logic        axi_awid, axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [31:0] axi_awaddr, axi_araddr;
  logic [7:0]  axi_awlen, axi_arlen, axi_wstrb;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic [63:0] axi_wdata, axi_rdata;
  logic        axi_bid, axi_bvalid, axi_bready;
  logic        axi_arid, axi_arvalid, axi_arready;
  logic        axi_rid, axi_rlast, axi_rvalid, axi_rready;

  int checks = 0;
  int errors = 0;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_misaligned(resp_misaligned), .busy(busy), .dbg(dbg),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0; axi_bid = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0; axi_rresp = 0; axi_rid = 0;
  endtask

  // Zero-wait read slave; lat counts the request cycle as cycle 1.
  task automatic load_txn(input logic [3:0] op, input logic [31:0] addr,
                          input logic [63:0] rd, input logic [1:0] rr,
                          output logic [31:0] data, output logic err, output logic mis,
                          output int lat, output int ar_cyc, output int busy_cyc,
                          output int resp_cnt, output logic [31:0] ar_addr,
                          output logic [2:0] ar_size);
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = '0;
    axi_arready = 1; axi_rvalid = 1; axi_rlast = 1; axi_rdata = rd; axi_rresp = rr;
    data = '0; err = 0; mis = 0; lat = 0; ar_cyc = 0; busy_cyc = 0; resp_cnt = 0;
    ar_addr = '0; ar_size = '0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      req_valid = 0;
      if (busy) busy_cyc++;
      if (axi_arvalid) begin ar_cyc++; ar_addr = axi_araddr; ar_size = axi_arsize; end
      if (resp_valid) begin
        resp_cnt++;
        if (lat == 0) begin lat = k; data = resp_data; err = resp_err; mis = resp_misaligned; end
      end
    end
    slave_idle();
  endtask

  // Write slave with per-channel ready delays; bvalid answers bready.
  task automatic store_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input int aw_delay, input int w_delay, input logic [1:0] br,
                           output logic [31:0] aw_addr, output logic [2:0] aw_size,
                           output logic [63:0] w_data, output logic [7:0] w_strb,
                           output logic w_last, output int aw_cyc, output int w_cyc,
                           output int resp_cnt, output logic err, output logic [31:0] data);
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
    aw_addr = '0; aw_size = '0; w_data = '0; w_strb = '0; w_last = 0;
    aw_cyc = 0; w_cyc = 0; resp_cnt = 0; err = 0; data = 32'hFFFF_FFFF;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      req_valid = 0;
      if (axi_awvalid) begin aw_cyc++; aw_addr = axi_awaddr; aw_size = axi_awsize; end
      if (axi_wvalid) begin w_cyc++; w_data = axi_wdata; w_strb = axi_wstrb; w_last = axi_wlast; end
      if (resp_valid) begin resp_cnt++; err = resp_err; data = resp_data; end
      axi_awready = (k >= aw_delay + 1);
      axi_wready  = (k >= w_delay + 1);
      axi_bvalid  = axi_bready;
      axi_bresp   = br;
    end
    slave_idle();
  endtask

  logic [31:0] d, a;
  logic [2:0]  sz;
  logic        e, m, wl;
  logic [63:0] wd;
  logic [7:0]  ws;
  int          lat, arc, bc, rc, awc, wc;

  initial begin
    rst = 1; req_valid = 0; req_op = '0; req_addr = '0; req_wdata = '0;
    slave_idle();
    repeat (2) @(negedge clk);
    chk("reset_valids", {req_ready, resp_valid, busy, axi_arvalid, axi_rready,
                         axi_awvalid, axi_wvalid, axi_bready}, 8'h00);
    chk("reset_resp", {resp_data, resp_err, resp_misaligned}, 34'h0);
    chk("reset_state", dbg.state, S_IDLE);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", {req_ready, busy}, 2'b10);

    // LB sign-extend from byte lane 3
    load_txn(4'b0000, 32'h1003, 64'h0000_0000_8000_0000, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("lb_data", d, 32'hFFFF_FF80);
    chk("lb_araddr", a, 32'h1003);
    chk("lb_arsize", sz, 3'd0);
    chk("lb_latency", lat, 4);
    chk("lb_flags", {e, m, arc, rc}, {1'b0, 1'b0, 32'd1, 32'd1});
    chk("lb_busy_cycles", bc, 3);

    load_txn(4'b0101, 32'h2006, 64'hBEEF_0000_0000_0000, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("lhu_data", d, 32'h0000_BEEF);
    chk("lhu_arsize", sz, 3'd1);
    load_txn(4'b0001, 32'h2006, 64'hBEEF_0000_0000_0000, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("lh_data", d, 32'hFFFF_BEEF);
    load_txn(4'b0100, 32'h6001, 64'h0000_0000_0000_A500, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("lbu_data", d, 32'h0000_00A5);
    load_txn(4'b0010, 32'h5004, 64'h1122_3344_0000_0000, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("lw_data", d, 32'h1122_3344);
    chk("lw_arsize", sz, 3'd2);

    // Misaligned LW: no bus access, two-cycle turnaround
    load_txn(4'b0010, 32'h4002, 64'h0, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("mis_flag", m, 1'b1);
    chk("mis_latency", lat, 2);
    chk("mis_no_ar", arc, 0);
    chk("mis_busy_cycles", bc, 1);
    chk("mis_data", {d, e}, 33'h0);
    load_txn(4'b0011, 32'h4000, 64'h0, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("illegal_size", {m, 32'(arc)}, {1'b1, 32'd0});
    load_txn(4'b0001, 32'h4001, 64'h0, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("mis_half", {m, 32'(arc)}, {1'b1, 32'd0});

    load_txn(4'b0010, 32'h5000, 64'h1234_5678_9ABC_DEF0, 2'b10, d, e, m, lat, arc, bc, rc, a, sz);
    chk("load_err", {e, d}, {1'b1, 32'h0});

    // SW with awready three cycles late
    store_txn(4'b1010, 32'h3004, 32'hDEAD_BEEF, 3, 0, 2'b00, a, sz, wd, ws, wl, awc, wc, rc, e, d);
    chk("sw_awaddr", a, 32'h3004);
    chk("sw_awsize", sz, 3'd2);
    chk("sw_wdata", wd, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("sw_wstrb", ws, 8'hF0);
    chk("sw_wlast", wl, 1'b1);
    chk("sw_aw_cycles", awc, 4);
    chk("sw_w_cycles", wc, 1);
    chk("sw_resp", {32'(rc), e, d}, {32'd1, 1'b0, 32'h0});

    // SB with wready late and a bus error response
    store_txn(4'b1000, 32'h7005, 32'h0000_00A5, 0, 2, 2'b11, a, sz, wd, ws, wl, awc, wc, rc, e, d);
    chk("sb_wdata", wd, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("sb_wstrb", ws, 8'h20);
    chk("sb_cycles", {32'(awc), 32'(wc)}, {32'd1, 32'd3});
    chk("sb_err", {32'(rc), e, d}, {32'd1, 1'b1, 32'h0});

    store_txn(4'b1001, 32'h3002, 32'h0000_1234, 1, 1, 2'b00, a, sz, wd, ws, wl, awc, wc, rc, e, d);
    chk("sh_wdata", wd, 64'h1234_1234_1234_1234);
    chk("sh_wstrb", ws, 8'h0C);

    // Asynchronous reset while waiting in RD_DATA
    @(negedge clk);
    req_valid = 1; req_op = 4'b0010; req_addr = 32'h8000; axi_arready = 1;
    @(negedge clk);
    req_valid = 0;
    chk("rst_pre_ar", axi_arvalid, 1'b1);
    @(negedge clk);
    chk("rst_pre_rd", {axi_rready, dbg.state}, {1'b1, S_RD_DATA});
    #2 rst = 1;
    #1 chk("rst_async", {axi_arvalid, axi_rready, busy, resp_valid}, 4'b0000);
    slave_idle();
    @(negedge clk);
    rst = 0;
    rc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) rc++;
    end
    chk("rst_no_resp", rc, 0);

    load_txn(4'b0010, 32'h9000, 64'h0000_0000_CAFE_F00D, 2'b00, d, e, m, lat, arc, bc, rc, a, sz);
    chk("post_rst_data", d, 32'hCAFE_F00D);
    chk("post_rst_latency", lat, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
